gate_sequencer: RTL and testbench
=================================

GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 SHALL have parameter GATE_W, default 24, giving the width of the gate-length counter in clk cycles.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin one measurement.
REQ-005 SHALL have port abort, input, 1, cancels any measurement in progress.
REQ-006 SHALL have port gate_len, input, GATE_W, gate length in cycles, sampled only when start is accepted.
REQ-007 SHALL have port cnt_in, input, 16, count value from the free-running pulse counter.
REQ-008 SHALL have port cnt_run, output, 1, run enable driven to the pulse counter.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have ports res_data (output, 16), res_valid (output, 1) and res_ready (input, 1), forming the result valid/ready channel.

Function
REQ-011 SHALL implement four states: IDLE, GATE, DRAIN and HOLD.
REQ-012 In IDLE, start=1 with gate_len!=0 SHALL perform the following on the same edge: latch gate_len, capture cnt_in into a snapshot register, and enter GATE.
REQ-013 In IDLE, start=1 with gate_len==0 SHALL be ignored, with no state change.
REQ-014 cnt_run SHALL be registered and high in GATE only, for exactly gate_len consecutive cycles.
REQ-015 GATE SHALL decrement the latched length each cycle and enter DRAIN when it reaches 1.
REQ-016 DRAIN SHALL last exactly 1 cycle, so that the counter's final increment settles; it then enters HOLD.
REQ-017 On entering HOLD, res_data SHALL equal (cnt_in - snapshot) mod 2^16; this makes counter wrap-around transparent.
REQ-018 In HOLD, res_valid SHALL be 1, and res_data SHALL remain stable until res_valid&&res_ready.
REQ-019 A HOLD handshake SHALL return the block to IDLE on the next edge, with res_valid low.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 abort=1 in any state SHALL force IDLE on the next edge, with cnt_run=0 and res_valid=0; no result is produced.
REQ-022 abort SHALL take priority over a simultaneous start or handshake.
REQ-023 Latency from start to res_valid SHALL be gate_len+2 cycles.
REQ-024 res_data SHALL hold its last value in IDLE.

Reset
REQ-025 While rst_n=0, the block SHALL be in state IDLE with outputs cnt_run=0, busy=0, res_valid=0 and res_data=16'h0000, and with snapshot and length registers at 0.
REQ-026 Reset assertion mid-measurement SHALL discard the measurement immediately.
REQ-027 After reset release, the block SHALL accept start on the first clk edge.

Configuration
REQ-028 Macro GATE_SEQ_AUTO_REARM_EN SHALL select auto re-arm behaviour.
REQ-029 With GATE_SEQ_AUTO_REARM_EN defined, a HOLD handshake SHALL re-enter GATE directly, reusing the latched length and recapturing the snapshot from cnt_in, until abort.
REQ-030 With GATE_SEQ_AUTO_REARM_EN undefined, the block SHALL perform single-shot operation per REQ-019.

Structure
REQ-031 Shared package gate_seq_pkg SHALL hold the state enum typedef, the constant CNT_W=16, and the default GATE_W.
REQ-032 The block SHALL be a single module with no sub-modules; the gate down-counter stays inline.

Verification
REQ-033 Basic measurement: gate_len=10, one input pulse per 2 cycles -> cnt_run high for 10 cycles, res_valid at cycle 12, res_data=5.
REQ-034 Wrap-around: cnt_in snapshot=16'hFFFE, 4 pulses during the gate -> res_data=4.
REQ-035 Backpressure: res_ready held low for 20 cycles -> res_valid and res_data stable; a start issued during this time is ignored.
REQ-036 Abort: abort on cycle 3 of a 100-cycle gate -> cnt_run=0 and busy=0 next cycle, with no res_valid.
REQ-037 Reset and zero length: rst_n pulsed low mid-GATE -> all outputs 0; start with gate_len=0 -> busy stays 0.
REQ-038 Auto re-arm (macro defined): three handshakes -> three results with gate_len cycles of cnt_run each; abort stops the sequence.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate sequencer: state encoding,
// counter width and the default gate-length width.
package gate_seq_pkg;

   localparam int CNT_W          = 16;
   localparam int GATE_W_DEFAULT = 24;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GATE  = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } gate_state_t;

endpackage

// File: rtl/gate_sequencer.sv
// Gated pulse-count measurement; start to res_valid is gate_len+2 cycles, result held until res_ready.
// Define GATE_SEQ_AUTO_REARM_EN to re-enter the gate straight after each result handshake until abort.
module gate_sequencer
   import gate_seq_pkg::*;
#(
   parameter int GATE_W = GATE_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [CNT_W-1:0]  cnt_in,
   output logic              cnt_run,
   output logic              busy,
   output logic [CNT_W-1:0]  res_data,
   output logic              res_valid,
   input  logic              res_ready
);

   gate_state_t       state, state_nxt;
   logic [GATE_W-1:0] len_q, len_nxt;
   logic [GATE_W-1:0] left_q, left_nxt;
   logic [CNT_W-1:0]  snap_q, snap_nxt;
   logic [CNT_W-1:0]  data_nxt;

   assign busy      = (state != S_IDLE);
   assign res_valid = (state == S_HOLD);

   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      left_nxt  = left_q;
      snap_nxt  = snap_q;
      data_nxt  = res_data;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && (gate_len != '0)) begin
                  state_nxt = S_GATE;
                  len_nxt   = gate_len;
                  left_nxt  = gate_len;
                  snap_nxt  = cnt_in;
               end
            end
            S_GATE: begin
               left_nxt = left_q - GATE_W'(1);
               if (left_q == GATE_W'(1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
               // Counter's last in-gate increment is visible now; modular subtract hides wrap.
               state_nxt = S_HOLD;
               data_nxt  = cnt_in - snap_q;
            end
            S_HOLD: begin
               if (res_ready) begin
`ifdef GATE_SEQ_AUTO_REARM_EN
                  state_nxt = S_GATE;
                  left_nxt  = len_q;
                  snap_nxt  = cnt_in;
`else
                  state_nxt = S_IDLE;
`endif
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         len_q    <= '0;
         left_q   <= '0;
         snap_q   <= '0;
         res_data <= '0;
         cnt_run  <= 1'b0;
      end else begin
         state    <= state_nxt;
         len_q    <= len_nxt;
         left_q   <= left_nxt;
         snap_q   <= snap_nxt;
         res_data <= data_nxt;
         cnt_run  <= (state_nxt == S_GATE);
      end
   end

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: a pulse counter fed by cnt_run, a cycle-timeline
// reference model checked every cycle, and directed cases with literal results.
module tb_gate_sequencer;
   import gate_seq_pkg::*;

   localparam int GW = GATE_W_DEFAULT;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, res_ready, cnt_load;
   logic          pulse = 1'b0;
   logic [GW-1:0] gate_len;
   logic [15:0]   cnt_in, cnt_load_val, res_data;
   logic          cnt_run, busy, res_valid;
   int            pulse_mode;
   int            n_checks = 0;
   int            n_fail = 0;
   int            lat, runs;

   always #5 clk = ~clk;

   gate_sequencer #(.GATE_W(GW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .gate_len  (gate_len),
      .cnt_in    (cnt_in),
      .cnt_run   (cnt_run),
      .busy      (busy),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   // External pulse counter: counts pulses only while the sequencer runs it.
   always @(posedge clk) begin
      if (cnt_load) cnt_in <= cnt_load_val;
      else if (cnt_run && pulse) cnt_in <= cnt_in + 16'd1;
   end

   // 0 random, 1 alternating, 2 every cycle, other none
   always @(posedge clk) begin
      #1;
      case (pulse_mode)
         0:       pulse = 1'($urandom_range(0, 1));
         1:       pulse = ~pulse;
         2:       pulse = 1'b1;
         default: pulse = 1'b0;
      endcase
   end

   // Reference model: m_el is the index of the cycle now starting within a measurement.
   bit          m_act = 1'b0;
   bit          m_hold = 1'b0;
   int          m_el = 0;
   int          m_len = 0;
   int          m_pulses = 0;
   logic [15:0] m_data = 16'h0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_act = 1'b0; m_hold = 1'b0; m_data = 16'h0;
      end else if (abort) begin
         m_act = 1'b0; m_hold = 1'b0;
      end else if (!m_act) begin
         if (start && gate_len != '0) begin
            m_act = 1'b1; m_len = int'(gate_len); m_el = 1; m_pulses = 0;
         end
      end else if (m_hold) begin
         if (res_ready) begin
            m_hold = 1'b0;
`ifdef GATE_SEQ_AUTO_REARM_EN
            m_el = 1; m_pulses = 0;
`else
            m_act = 1'b0;
`endif
         end
      end else begin
         if (m_el <= m_len && pulse) m_pulses++;
         m_el++;
         if (m_el == m_len + 2) begin
            m_hold = 1'b1;
            m_data = 16'(m_pulses);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n)
         chk("reset_outputs", 32'({cnt_run, busy, res_valid, res_data}), 32'h0);
      else
         chk("model", 32'({cnt_run, busy, res_valid, res_data}),
             32'({(m_act && !m_hold && m_el <= m_len), m_act, m_hold, m_data}));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      start = 1'b1;
      gate_len = GW'(len);
      tick();
      start = 1'b0;
   endtask

   // Call in gate cycle 1; returns the cycle index at which res_valid rose (0 = never).
   task automatic wait_result(input int budget, output int l, output int r);
      l = 0;
      r = 0;
      for (int c = 1; c <= budget; c++) begin
         if (cnt_run) r++;
         if (res_valid) begin
            l = c;
            break;
         end
         tick();
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic close_result();
      handshake();
`ifdef GATE_SEQ_AUTO_REARM_EN
      chk("rearm_after_hs", 32'({busy, cnt_run, res_valid}), 32'b110);
      abort = 1'b1;
      tick();
      abort = 1'b0;
`endif
      chk("idle_after_hs", 32'({busy, cnt_run, res_valid}), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      gate_len = '0; cnt_load = 1'b1; cnt_load_val = 16'h1234; pulse_mode = 3;
      #1;
      chk("reset_state", 32'({cnt_run, busy, res_valid, res_data}), 32'h0);
      repeat (3) tick();
      cnt_load = 1'b0;

      // Start accepted on the first edge after reset release
      rst_n = 1'b1;
      do_start(3);
      chk("start_after_reset", 32'({busy, cnt_run}), 32'b11);
      wait_result(20, lat, runs);
      chk("latency_len3", 32'(lat), 32'd5);
      chk("result_no_pulses", 32'(res_data), 32'h0);
      close_result();

      // Basic measurement: 10-cycle gate, a pulse every other cycle
      pulse_mode = 1;
      tick();
      do_start(10);
      wait_result(40, lat, runs);
      chk("basic_latency", 32'(lat), 32'd12);
      chk("basic_run_cycles", 32'(runs), 32'd10);
      chk("basic_data", 32'(res_data), 32'd5);
      close_result();

      // Wrap-around of the pulse counter
      pulse_mode = 2;
      cnt_load = 1'b1; cnt_load_val = 16'hFFFE;
      tick();
      cnt_load = 1'b0;
      do_start(4);
      wait_result(20, lat, runs);
      chk("wrap_latency", 32'(lat), 32'd6);
      chk("wrap_data", 32'(res_data), 32'd4);
      close_result();

      // Backpressure: result held for 20 cycles, start ignored meanwhile
      do_start(8);
      wait_result(30, lat, runs);
      chk("bp_latency", 32'(lat), 32'd10);
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         gate_len = GW'(7);
         tick();
         chk("bp_hold", 32'({res_valid, busy, cnt_run, res_data}), 32'({3'b110, 16'd8}));
      end
      start = 1'b0;
      close_result();

      // Abort beats handshake; res_data keeps the last result
      do_start(3);
      wait_result(20, lat, runs);
      abort = 1'b1; res_ready = 1'b1;
      tick();
      abort = 1'b0; res_ready = 1'b0;
      chk("abort_vs_hs", 32'({busy, res_valid, res_data}), 32'd3);
      // Abort beats start in idle
      abort = 1'b1;
      do_start(5);
      abort = 1'b0;
      chk("abort_vs_start", 32'({busy, cnt_run}), 32'h0);

      // Abort on cycle 3 of a 100-cycle gate
      pulse_mode = 0;
      do_start(100);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outputs", 32'({cnt_run, busy, res_valid}), 32'h0);
      repeat (110) tick();
      chk("abort_no_result", 32'({busy, res_valid}), 32'h0);

      // Reset mid-gate, then zero-length start
      do_start(50);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("reset_mid_gate", 32'({cnt_run, busy, res_valid, res_data}), 32'h0);
      tick();
      rst_n = 1'b1;
      do_start(0);
      chk("zero_len_ignored", 32'({busy, cnt_run}), 32'h0);
      tick();
      chk("zero_len_idle", 32'(busy), 32'h0);

`ifdef GATE_SEQ_AUTO_REARM_EN
      do_start(6);
      for (int k = 0; k < 3; k++) begin
         wait_result(30, lat, runs);
         chk("rearm_latency", 32'(lat), 32'd8);
         chk("rearm_run_cycles", 32'(runs), 32'd6);
         handshake();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("rearm_abort", 32'({busy, cnt_run, res_valid}), 32'h0);
`endif

      // Randomised traffic checked by the model every cycle
      pulse_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(0, 7) == 0);
         gate_len  = GW'($urandom_range(0, 12));
         abort     = ($urandom_range(0, 63) == 0);
         res_ready = ($urandom_range(0, 3) == 0);
         rst_n     = ($urandom_range(0, 399) != 0);
         tick();
      end
      start = 1'b0; abort = 1'b0; res_ready = 1'b0; rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
